// File: rtl/lcd_dma_pkg.sv
// Shared state encoding and unpack constants for the LCD DMA prefetch path.
package lcd_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fsm_state_t;

  localparam int DEF_WORD_WIDTH  = 32;
  localparam int DEF_PIXEL_WIDTH = 16;
  localparam int PIXELS_PER_WORD = DEF_WORD_WIDTH / DEF_PIXEL_WIDTH;

  function automatic int pixels_per_word(input int word_width, input int pixel_width);
    return word_width / pixel_width;
  endfunction

endpackage

// File: rtl/lcd_dma_prefetch_fifo_fifo.sv
// Single-clock first-word-fall-through FIFO: head is valid whenever empty is low.
module sync_fwft_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_r [0:(2**DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full      = (count_r == DEPTH);
  assign empty     = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
  assign level     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  // Storage write port, left without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_dma_prefetch_fifo.sv
// LCD frame-buffer prefetcher: credit-limited burst DMA reads into a FWFT FIFO,
// unpacked into pixels for the timing generator.
module lcd_dma_prefetch_fifo
  import lcd_dma_pkg::*;
#(
  parameter int ADDR_WIDTH       = 30,
  parameter int WORD_WIDTH       = 32,
  parameter int PIXEL_WIDTH      = 16,
  parameter int FIFO_DEPTH_LOG2  = 9,
  parameter int BURST_SIZE       = 8,
  parameter int BURST_COUNT_BITS = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [ADDR_WIDTH-1:0]       BUFFER_START_ADDRESS,
  input  logic [BURST_COUNT_BITS-1:0] BUFFER_BURSTS,
  output logic [ADDR_WIDTH-1:0]       DMA_RD_ADDR,
  output logic                        DMA_START,
  input  logic                        DMA_READY,
  input  logic [WORD_WIDTH-1:0]       DMA_RD_DATA,
  input  logic                        DMA_RD_DATA_VALID,
  input  logic                        START,
  input  logic                        STOP,
  input  logic                        RDEN,
  output logic [PIXEL_WIDTH-1:0]      RDDATA,
  output logic [FIFO_DEPTH_LOG2:0]    LEVEL,
  output logic                        BUSY,
  output logic                        UNDERFLOW,
  output logic                        OVERFLOW
);

  localparam int PPW   = pixels_per_word(WORD_WIDTH, PIXEL_WIDTH);
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int LVL_W = FIFO_DEPTH_LOG2 + 1;

  localparam logic [IDX_W-1:0]            IDX_LAST     = IDX_W'(PPW - 1);
  localparam logic [IDX_W-1:0]            IDX_ONE      = IDX_W'(1);
  localparam logic [LVL_W-1:0]            LVL_ONE      = LVL_W'(1);
  localparam logic [LVL_W-1:0]            BURST_OUT    = LVL_W'(BURST_SIZE);
  localparam logic [LVL_W:0]              BURST_CREDIT = (LVL_W + 1)'(BURST_SIZE);
  localparam logic [LVL_W:0]              CREDIT_LIMIT = (LVL_W + 1)'(2 ** FIFO_DEPTH_LOG2);
  localparam logic [ADDR_WIDTH-1:0]       ADDR_STEP    = ADDR_WIDTH'(BURST_SIZE);
  localparam logic [BURST_COUNT_BITS-1:0] BURSTS_ONE   = BURST_COUNT_BITS'(1);

  generate
    if ((WORD_WIDTH % PIXEL_WIDTH) != 0) begin : g_bad_pixel_width
      $error("PIXEL_WIDTH must divide WORD_WIDTH");
    end
    if ((BURST_SIZE < 1) || ((BURST_SIZE & (BURST_SIZE - 1)) != 0) ||
        (BURST_SIZE > (2 ** FIFO_DEPTH_LOG2))) begin : g_bad_burst_size
      $error("BURST_SIZE must be a power of 2 no larger than the FIFO depth");
    end
  endgenerate

  fsm_state_t                  state_r;
  logic [ADDR_WIDTH-1:0]       addr_r;
  logic [ADDR_WIDTH-1:0]       dma_addr_r;
  logic [BURST_COUNT_BITS-1:0] bursts_left_r;
  logic [LVL_W-1:0]            outstanding_r;
  logic [LVL_W-1:0]            out_next_s;
  logic                        pending_r;
  logic                        dma_start_r;
  logic [IDX_W-1:0]            idx_r;
  logic [PIXEL_WIDTH-1:0]      rddata_r;
  logic                        underflow_r;
  logic                        overflow_r;

  logic [WORD_WIDTH-1:0] fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [LVL_W-1:0]      fifo_level_s;
  logic                  credit_ok_s, abort_s, issue_s, valid_expected_s, wr_attempt_s;
  logic                  push_s, pop_s, rd_hit_s, idle_discard_s;
  logic                  pend_eff_s, drain_done_s, start_take_s, start_ok_s;

  assign credit_ok_s      = ({1'b0, fifo_level_s} + {1'b0, outstanding_r} + BURST_CREDIT) <= CREDIT_LIMIT;
  assign abort_s          = ((state_r == ISSUE) || (state_r == WAIT)) && (START || STOP);
  assign issue_s          = (state_r == ISSUE) && !abort_s && DMA_READY && credit_ok_s &&
                            (bursts_left_r != {BURST_COUNT_BITS{1'b0}});
  // Data with nothing outstanding is stray and never counted or stored.
  assign valid_expected_s = DMA_RD_DATA_VALID && (outstanding_r != {LVL_W{1'b0}});
  assign wr_attempt_s     = valid_expected_s && (state_r != DRAIN) && !abort_s;
  assign push_s           = wr_attempt_s && !fifo_full_s;
  assign rd_hit_s         = RDEN && !fifo_empty_s;
  assign idle_discard_s   = (state_r == IDLE) && !RDEN && !fifo_empty_s;
  assign pop_s            = (rd_hit_s && (idx_r == IDX_LAST)) || idle_discard_s;
  assign pend_eff_s       = pending_r || START;
  assign drain_done_s     = (state_r == DRAIN) && (outstanding_r == {LVL_W{1'b0}});
  assign start_take_s     = ((state_r == IDLE) && START) || (drain_done_s && pend_eff_s);
  assign start_ok_s       = (BUFFER_START_ADDRESS != {ADDR_WIDTH{1'b0}}) &&
                            (BUFFER_BURSTS != {BURST_COUNT_BITS{1'b0}});

  sync_fwft_fifo #(
    .WIDTH      (WORD_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push_s),
    .wdata (DMA_RD_DATA),
    .pop   (pop_s),
    .flush (abort_s),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Words in flight: grows by a burst on each request, shrinks per received word.
  always_comb begin
    out_next_s = outstanding_r;
    if (issue_s) out_next_s = out_next_s + BURST_OUT;
    else         out_next_s = out_next_s;
    if (valid_expected_s) out_next_s = out_next_s - LVL_ONE;
    else                  out_next_s = out_next_s;
  end

  // Request FSM with abort, drain and pending-restart handling.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_WIDTH{1'b0}};
      dma_addr_r    <= {ADDR_WIDTH{1'b0}};
      bursts_left_r <= {BURST_COUNT_BITS{1'b0}};
      outstanding_r <= {LVL_W{1'b0}};
      pending_r     <= 1'b0;
      dma_start_r   <= 1'b0;
    end else begin
      dma_start_r   <= 1'b0;
      outstanding_r <= out_next_s;
      case (state_r)
        IDLE: begin
          if (START) begin
            addr_r        <= BUFFER_START_ADDRESS;
            bursts_left_r <= BUFFER_BURSTS;
            state_r       <= start_ok_s ? ISSUE : IDLE;
          end
        end
        ISSUE: begin
          if (abort_s) begin
            pending_r <= START;
            state_r   <= DRAIN;
          end else if (issue_s) begin
            dma_start_r   <= 1'b1;
            dma_addr_r    <= addr_r;
            addr_r        <= addr_r + ADDR_STEP;
            bursts_left_r <= bursts_left_r - BURSTS_ONE;
            state_r       <= WAIT;
          end
        end
        WAIT: begin
          if (abort_s) begin
            pending_r <= START;
            state_r   <= DRAIN;
          end else begin
            state_r <= ISSUE;
          end
        end
        DRAIN: begin
          if (drain_done_s) begin
            pending_r <= 1'b0;
            if (pend_eff_s) begin
              addr_r        <= BUFFER_START_ADDRESS;
              bursts_left_r <= BUFFER_BURSTS;
              state_r       <= start_ok_s ? ISSUE : IDLE;
            end else begin
              state_r <= IDLE;
            end
          end else if (START) begin
            pending_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Pixel unpack from the FIFO head, plus sticky error flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rddata_r    <= {PIXEL_WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (RDEN && fifo_empty_s) rddata_r <= {PIXEL_WIDTH{1'b0}};
      else if (rd_hit_s)        rddata_r <= fifo_head_s[idx_r*PIXEL_WIDTH +: PIXEL_WIDTH];

      if (abort_s || idle_discard_s || (RDEN && fifo_empty_s)) idx_r <= {IDX_W{1'b0}};
      else if (rd_hit_s) idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_ONE;

      if (RDEN && fifo_empty_s) underflow_r <= 1'b1;
      else if (start_take_s)    underflow_r <= 1'b0;

      if (wr_attempt_s && fifo_full_s) overflow_r <= 1'b1;
      else if (start_take_s)           overflow_r <= 1'b0;
    end
  end

  assign DMA_RD_ADDR = dma_addr_r;
  assign DMA_START   = dma_start_r;
  assign RDDATA      = rddata_r;
  assign LEVEL       = fifo_level_s;
  assign BUSY        = (state_r != IDLE);
  assign UNDERFLOW   = underflow_r;
  assign OVERFLOW    = overflow_r;

endmodule

// File: tb/tb_lcd_dma_prefetch_fifo.sv
// Self-checking bench: DMA responder model, pixel scoreboard, vector table and corner sequences.
module tb_lcd_dma_prefetch_fifo;

  localparam int AW = 30;
  localparam int WW = 32;
  localparam int PW = 16;
  localparam int DL = 5;
  localparam int BS = 8;
  localparam int BC = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] BUFFER_START_ADDRESS;
  logic [BC-1:0] BUFFER_BURSTS;
  logic [AW-1:0] DMA_RD_ADDR;
  logic          DMA_START;
  logic          DMA_READY;
  logic [WW-1:0] DMA_RD_DATA;
  logic          DMA_RD_DATA_VALID;
  logic          START, STOP, RDEN;
  logic [PW-1:0] RDDATA;
  logic [DL:0]   LEVEL;
  logic          BUSY, UNDERFLOW, OVERFLOW;

  lcd_dma_prefetch_fifo #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .PIXEL_WIDTH(PW),
    .FIFO_DEPTH_LOG2(DL), .BURST_SIZE(BS), .BURST_COUNT_BITS(BC)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .BUFFER_START_ADDRESS(BUFFER_START_ADDRESS), .BUFFER_BURSTS(BUFFER_BURSTS),
    .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
    .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
    .START(START), .STOP(STOP), .RDEN(RDEN), .RDDATA(RDDATA), .LEVEL(LEVEL),
    .BUSY(BUSY), .UNDERFLOW(UNDERFLOW), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BC-1:0] bursts;
    logic          exp_busy;
    int            exp_starts;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  resp_t         resp_q[$];
  logic [31:0]   custom_q[$];
  logic [PW-1:0] exp_pix[$];
  logic [AW-1:0] addr_log[$];
  int  cyc = 0, lat = 2, start_cnt = 0, consec_err = 0, level_peak = 0, last_word_cyc = 0;
  logic draining = 1'b0;
  logic prev_start = 1'b0;
  int  pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // DMA responder: records requests, returns each burst after lat cycles, feeds the scoreboard.
  initial begin
    logic [31:0] w;
    DMA_RD_DATA_VALID = 1'b0;
    DMA_RD_DATA       = 32'd0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (int'(LEVEL) > level_peak) level_peak = int'(LEVEL);
      if (RESET) begin
        resp_q.delete();
        prev_start        = 1'b0;
        DMA_RD_DATA_VALID = 1'b0;
        DMA_RD_DATA       = 32'd0;
      end else begin
        if (DMA_START) begin
          if (prev_start) consec_err++;
          start_cnt++;
          addr_log.push_back(DMA_RD_ADDR);
          for (int i = 0; i < BS; i++) begin
            if (custom_q.size() > 0) w = custom_q.pop_front();
            else w = {DMA_RD_ADDR[15:0] + 16'(i), 16'hC0DE ^ 16'(i)};
            resp_q.push_back('{data: w, due: cyc + lat + i});
          end
        end
        prev_start = DMA_START;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
          DMA_RD_DATA_VALID = 1'b1;
          DMA_RD_DATA       = resp_q[0].data;
          last_word_cyc     = cyc;
          if (!draining) begin
            exp_pix.push_back(resp_q[0].data[15:0]);
            exp_pix.push_back(resp_q[0].data[31:16]);
          end
          void'(resp_q.pop_front());
        end else begin
          DMA_RD_DATA_VALID = 1'b0;
          DMA_RD_DATA       = 32'd0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_start(input logic [AW-1:0] a, input logic [BC-1:0] b);
    draining             = 1'b0;
    BUFFER_START_ADDRESS = a;
    BUFFER_BURSTS        = b;
    START                = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic pulse_stop();
    draining = 1'b1;
    STOP     = 1'b1;
    @(negedge CLK);
    STOP = 1'b0;
    exp_pix.delete();
  endtask

  task automatic wait_level(input int n, input string nm);
    int k = 0;
    while (int'(LEVEL) < n && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk(nm, 64'(LEVEL), 64'(n));
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (BUSY && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk(nm, 64'(BUSY), 64'd0);
  endtask

  task automatic read_n(input int n, input string nm);
    logic [PW-1:0] e;
    for (int i = 0; i < n; i++) begin
      RDEN = 1'b1;
      @(negedge CLK);
      e = (exp_pix.size() > 0) ? exp_pix.pop_front() : 16'hDEAD;
      chk(nm, 64'(RDDATA), 64'(e));
    end
    RDEN = 1'b0;
  endtask

  vec_t vecs[4];
  logic [PW-1:0] unpack_pix[4];
  logic [DL:0]   unpack_lvl[4];

  initial begin
    int base, bidx, fall_cyc;
    vecs[0] = '{addr: 30'h0,        bursts: 16'd4, exp_busy: 1'b0, exp_starts: 0, exp_last_addr: 30'h0};
    vecs[1] = '{addr: 30'h100,      bursts: 16'd0, exp_busy: 1'b0, exp_starts: 0, exp_last_addr: 30'h0};
    vecs[2] = '{addr: 30'h200,      bursts: 16'd1, exp_busy: 1'b1, exp_starts: 1, exp_last_addr: 30'h200};
    vecs[3] = '{addr: 30'h3FFFFFF8, bursts: 16'd2, exp_busy: 1'b1, exp_starts: 2, exp_last_addr: 30'h0};
    unpack_pix[0] = 16'h5555; unpack_pix[1] = 16'hAAAA;
    unpack_pix[2] = 16'h5678; unpack_pix[3] = 16'h1234;
    unpack_lvl[0] = 6'd8; unpack_lvl[1] = 6'd7; unpack_lvl[2] = 6'd7; unpack_lvl[3] = 6'd6;

    RESET = 1'b1; DMA_READY = 1'b1; START = 1'b0; STOP = 1'b0; RDEN = 1'b0;
    BUFFER_START_ADDRESS = '0; BUFFER_BURSTS = '0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 64'({DMA_START, DMA_RD_ADDR, RDDATA, LEVEL, BUSY, UNDERFLOW, OVERFLOW}), 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Frame fetch: four bursts from 0x100
    base = start_cnt; bidx = addr_log.size(); level_peak = 0;
    pulse_start(30'h100, 16'd4);
    wait_level(32, "fetch_level_full");
    repeat (10) @(negedge CLK);
    chk("fetch_start_count", 64'(start_cnt - base), 64'd4);
    for (int k = 0; k < 4; k++) chk("fetch_addr", 64'(addr_log[bidx + k]), 64'(30'h100 + 30'(8 * k)));
    chk("fetch_level_peak", 64'(level_peak), 64'd32);
    chk("fetch_no_overflow", 64'(OVERFLOW), 64'd0);
    read_n(64, "fetch_pixel");
    chk("fetch_level_empty", 64'(LEVEL), 64'd0);
    pulse_stop();
    wait_idle("fetch_idle");

    // Unpack order with known words
    custom_q.push_back(32'hAAAA5555);
    custom_q.push_back(32'h12345678);
    pulse_start(30'h300, 16'd1);
    wait_level(8, "unpack_level_fill");
    for (int k = 0; k < 4; k++) begin
      RDEN = 1'b1;
      @(negedge CLK);
      chk("unpack_pixel", 64'(RDDATA), 64'(unpack_pix[k]));
      chk("unpack_level", 64'(LEVEL), 64'(unpack_lvl[k]));
      void'(exp_pix.pop_front());
    end
    RDEN = 1'b0;
    read_n(12, "unpack_rest");
    pulse_stop();
    wait_idle("unpack_idle");

    // Credit limit with a 32-word FIFO
    base = start_cnt;
    pulse_start(30'h400, 16'd100);
    repeat (80) @(negedge CLK);
    chk("credit_start_count", 64'(start_cnt - base), 64'd4);
    chk("credit_level", 64'(LEVEL), 64'd32);
    chk("credit_no_overflow", 64'(OVERFLOW), 64'd0);
    read_n(16, "credit_pixel");
    repeat (30) @(negedge CLK);
    chk("credit_refill_start", 64'(start_cnt - base), 64'd5);
    chk("credit_refill_level", 64'(LEVEL), 64'd32);
    pulse_stop();
    wait_idle("credit_idle");

    // Abort with three bursts in flight
    lat = 40; base = start_cnt;
    pulse_start(30'h500, 16'd3);
    begin
      int k = 0;
      while (start_cnt - base < 3 && k < 50) begin
        @(negedge CLK);
        k++;
      end
    end
    chk("abort_starts", 64'(start_cnt - base), 64'd3);
    pulse_stop();
    chk("abort_busy_hold", 64'(BUSY), 64'd1);
    chk("abort_level_flushed", 64'(LEVEL), 64'd0);
    wait_idle("abort_busy_fall");
    fall_cyc = cyc;
    chk("abort_words_delivered", 64'(resp_q.size()), 64'd0);
    chk("abort_busy_after_last", 64'(fall_cyc > last_word_cyc), 64'd1);
    repeat (20) @(negedge CLK);
    chk("abort_no_more_start", 64'(start_cnt - base), 64'd3);
    chk("abort_level_zero", 64'(LEVEL), 64'd0);
    chk("abort_nothing_kept", 64'(exp_pix.size()), 64'd0);
    lat = 2;

    // Underflow on empty FIFO, sticky until the next START
    RDEN = 1'b1;
    @(negedge CLK);
    RDEN = 1'b0;
    chk("underflow_rddata", 64'(RDDATA), 64'd0);
    chk("underflow_flag", 64'(UNDERFLOW), 64'd1);
    repeat (5) @(negedge CLK);
    chk("underflow_sticky", 64'(UNDERFLOW), 64'd1);

    // Table: disable conditions and address wrap
    for (int v = 0; v < 4; v++) begin
      base = start_cnt; bidx = addr_log.size();
      pulse_start(vecs[v].addr, vecs[v].bursts);
      chk("vec_busy", 64'(BUSY), 64'(vecs[v].exp_busy));
      chk("vec_flags_cleared", 64'({UNDERFLOW, OVERFLOW}), 64'd0);
      repeat (30) @(negedge CLK);
      chk("vec_start_count", 64'(start_cnt - base), 64'(vecs[v].exp_starts));
      if (start_cnt > base) chk("vec_last_addr", 64'(addr_log[addr_log.size() - 1]), 64'(vecs[v].exp_last_addr));
      if (BUSY) pulse_stop();
      wait_idle("vec_idle");
      chk("vec_level", 64'(LEVEL), 64'd0);
    end

    // Asynchronous reset in the middle of a fetch
    pulse_start(30'h600, 16'd50);
    repeat (10) @(negedge CLK);
    #2 RESET = 1'b1;
    #1 chk("reset_async_outputs", 64'({DMA_START, DMA_RD_ADDR, RDDATA, LEVEL, BUSY, UNDERFLOW, OVERFLOW}), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    exp_pix.delete();
    custom_q.delete();
    base = start_cnt; bidx = addr_log.size();
    pulse_start(30'h700, 16'd2);
    wait_level(16, "post_reset_level");
    chk("post_reset_starts", 64'(start_cnt - base), 64'd2);
    chk("post_reset_addr0", 64'(addr_log[bidx]), 64'(30'h700));
    chk("post_reset_addr1", 64'(addr_log[bidx + 1]), 64'(30'h708));
    read_n(32, "post_reset_pixel");
    chk("post_reset_level_empty", 64'(LEVEL), 64'd0);
    pulse_stop();
    wait_idle("post_reset_idle");

    chk("no_back_to_back_start", 64'(consec_err), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
